dwc_pw_tile_sequencer: RTL and testbench

//   Control sequencer for the parallel-window DWC datapath. Accepts one
//   [KERNEL_PROD][CHANNELS] window per AXI-Stream input beat and emits NF*SF

---
 rtl/dwc_pw_tile_sequencer_if.sv | 43 ++++
 rtl/dwc_pw_tile_sequencer.sv | 109 ++++++++++
 tb/tb_dwc_pw_tile_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dwc_pw_tile_sequencer_if.sv
// Handshake and tile-select bundle for the DWC tile sequencer.
// master = sequencer side, slave = window source / tile consumer side.
interface dwc_pw_tile_sequencer_if #(
  parameter int SIMD        = 3,
  parameter int PE          = 2,
  parameter int CHANNELS    = 9,
  parameter int KERNEL_PROD = 4,
  parameter int IMG_H       = 2,
  parameter int IMG_W       = 2
);
  localparam int SF  = CHANNELS / SIMD;
  localparam int NF  = KERNEL_PROD / PE;
  localparam int SFW = ($clog2(SF) > 1) ? $clog2(SF) : 1;
  localparam int NFW = ($clog2(NF) > 1) ? $clog2(NF) : 1;
  localparam int HW  = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1;
  localparam int WW  = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1;

  logic           s_tvalid;
  logic           s_tready;
  logic           buf_we;
  logic           m_tvalid;
  logic           m_tready;
  logic [NFW-1:0] nf_idx;
  logic [SFW-1:0] sf_idx;
  logic           last_win;
  logic           last_img;
  logic [HW-1:0]  h_idx;
  logic [WW-1:0]  w_idx;

  modport master (
    input  s_tvalid, m_tready,
    output s_tready, buf_we, m_tvalid,
    output nf_idx, sf_idx, last_win, last_img,
    output h_idx, w_idx
  );

  modport slave (
    output s_tvalid, m_tready,
    input  s_tready, buf_we, m_tvalid,
    input  nf_idx, sf_idx, last_win, last_img,
    input  h_idx, w_idx
  );
endinterface

// File: rtl/dwc_pw_tile_sequencer.sv
// Tile sequencer for the parallel-window DWC datapath.
// One window in -> NF*SF tiles out (NF outer, SF inner), tracks (h,w).
module dwc_pw_tile_sequencer #(
  parameter int SIMD        = 3,
  parameter int PE          = 2,
  parameter int CHANNELS    = 9,
  parameter int KERNEL_PROD = 4,
  parameter int IMG_H       = 2,
  parameter int IMG_W       = 2
) (
  input  logic ap_clk,
  input  logic ap_rst,
  dwc_pw_tile_sequencer_if.master sq
);
  localparam int SF  = CHANNELS / SIMD;
  localparam int NF  = KERNEL_PROD / PE;
  localparam int SFW = ($clog2(SF) > 1) ? $clog2(SF) : 1;
  localparam int NFW = ($clog2(NF) > 1) ? $clog2(NF) : 1;
  localparam int HW  = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1;
  localparam int WW  = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1;

  localparam logic [SFW-1:0] SF_MAX = SFW'(SF - 1);
  localparam logic [NFW-1:0] NF_MAX = NFW'(NF - 1);
  localparam logic [HW-1:0]  H_MAX  = HW'(IMG_H - 1);
  localparam logic [WW-1:0]  W_MAX  = WW'(IMG_W - 1);

  if ((CHANNELS % SIMD) != 0) begin : g_bad_simd
    $error("CHANNELS must be a multiple of SIMD");
  end
  if ((KERNEL_PROD % PE) != 0) begin : g_bad_pe
    $error("KERNEL_PROD must be a multiple of PE");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t         r_state;
  logic           r_mvalid;
  logic [NFW-1:0] r_nf;
  logic [SFW-1:0] r_sf;
  logic [HW-1:0]  r_h;
  logic [WW-1:0]  r_w;

  logic w_last_win;
  logic w_last_img;
  logic w_xfer;
  logic w_s_tready;
  logic w_acc;

  assign w_last_win = (r_nf == NF_MAX) && (r_sf == SF_MAX);
  assign w_last_img = w_last_win && (r_h == H_MAX) && (r_w == W_MAX);
  assign w_xfer     = r_mvalid && sq.m_tready;
  // Ready on the last tile's transfer gives back-to-back windows.
  assign w_s_tready = !ap_rst &&
                      ((r_state == IDLE) || (w_xfer && w_last_win));
  assign w_acc      = sq.s_tvalid && w_s_tready;

  // Window/tile sequencing FSM with registered valid and indices.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= IDLE;
      r_mvalid <= 1'b0;
      r_nf     <= '0;
      r_sf     <= '0;
      r_h      <= '0;
      r_w      <= '0;
    end else if (w_xfer) begin
      if (w_last_win) begin
        r_nf <= '0;
        r_sf <= '0;
        if (r_w == W_MAX) begin
          r_w <= '0;
          r_h <= (r_h == H_MAX) ? '0 : r_h + 1'b1;
        end else begin
          r_w <= r_w + 1'b1;
        end
        if (w_acc) begin
          r_state  <= EMIT;
          r_mvalid <= 1'b1;
        end else begin
          r_state  <= IDLE;
          r_mvalid <= 1'b0;
        end
      end else if (r_sf == SF_MAX) begin
        r_sf <= '0;
        r_nf <= r_nf + 1'b1;
      end else begin
        r_sf <= r_sf + 1'b1;
      end
    end else if (w_acc) begin
      r_state  <= EMIT;
      r_mvalid <= 1'b1;
      r_nf     <= '0;
      r_sf     <= '0;
    end
  end

  assign sq.s_tready = w_s_tready;
  assign sq.buf_we   = w_acc;
  assign sq.m_tvalid = r_mvalid;
  assign sq.nf_idx   = r_nf;
  assign sq.sf_idx   = r_sf;
  assign sq.last_win = w_last_win;
  assign sq.last_img = w_last_img;
  assign sq.h_idx    = r_h;
  assign sq.w_idx    = r_w;
endmodule

// File: tb/tb_dwc_pw_tile_sequencer.sv
// Bench for dwc_pw_tile_sequencer: default build against a tile-count
// model, plus a SIMD=9/PE=4 build with one tile per window.
module tb_dwc_pw_tile_sequencer;
  localparam int SIMD = 3, PE = 2, CH = 9, KP = 4;
  localparam int IH = 2, IW = 2;
  localparam int SF = CH / SIMD;
  localparam int NF = KP / PE;
  localparam int NT = NF * SF;
  localparam int NWIN = IH * IW;

  logic clk = 1'b0;
  logic ap_rst = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  dwc_pw_tile_sequencer_if #(
    .SIMD(SIMD), .PE(PE), .CHANNELS(CH), .KERNEL_PROD(KP),
    .IMG_H(IH), .IMG_W(IW)
  ) bus ();

  dwc_pw_tile_sequencer #(
    .SIMD(SIMD), .PE(PE), .CHANNELS(CH), .KERNEL_PROD(KP),
    .IMG_H(IH), .IMG_W(IW)
  ) dut (
    .ap_clk(clk),
    .ap_rst(ap_rst),
    .sq(bus.master)
  );

  dwc_pw_tile_sequencer_if #(
    .SIMD(9), .PE(4), .CHANNELS(9), .KERNEL_PROD(4),
    .IMG_H(IH), .IMG_W(IW)
  ) b2 ();

  dwc_pw_tile_sequencer #(
    .SIMD(9), .PE(4), .CHANNELS(9), .KERNEL_PROD(4),
    .IMG_H(IH), .IMG_W(IW)
  ) dut2 (
    .ap_clk(clk),
    .ap_rst(rst2),
    .sq(b2.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state: tiles left in held window, window number in image
  int tl = 0;
  int wn = 0;
  int n_done = 0;
  int obs_x = 0;
  int obs_we = 0;
  int img_at = -1;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit sv, input bit mr);
    bit e_rdy;
    int k;
    @(negedge clk);
    ap_rst = rst;
    bus.s_tvalid = sv;
    bus.m_tready = mr;
    #1;
    e_rdy = !rst && (tl == 0 || (mr && tl == 1));
    chk("s_tready", 32'(bus.s_tready), 32'(e_rdy));
    chk("buf_we", 32'(bus.buf_we), 32'(sv && e_rdy));
    chk("m_tvalid", 32'(bus.m_tvalid), 32'(tl > 0));
    if (tl > 0) begin
      k = NT - tl;
      chk("nf_idx", 32'(bus.nf_idx), k / SF);
      chk("sf_idx", 32'(bus.sf_idx), k % SF);
      chk("last_win", 32'(bus.last_win), 32'(k == NT - 1));
      chk("last_img", 32'(bus.last_img),
          32'(k == NT - 1 && wn == NWIN - 1));
      chk("h_idx", 32'(bus.h_idx), wn / IW);
      chk("w_idx", 32'(bus.w_idx), wn % IW);
    end
    if (bus.m_tvalid && mr) obs_x++;
    if (bus.buf_we) obs_we++;
    if (bus.m_tvalid && bus.last_img && img_at < 0) img_at = cyc_n;
    cyc_n++;
    @(posedge clk);
    if (rst) begin
      tl = 0;
      wn = 0;
    end else begin
      if (tl > 0 && mr) begin
        tl--;
        if (tl == 0) begin
          wn = (wn + 1) % NWIN;
          n_done++;
        end
      end
      if (sv && e_rdy) tl = NT;
    end
  endtask

  initial begin
    int guard;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    b2.s_tvalid = 1'b0;
    b2.m_tready = 1'b0;

    // reset, then check reset state
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    @(negedge clk);
    #1;
    chk("rst_nf", 32'(bus.nf_idx), 0);
    chk("rst_sf", 32'(bus.sf_idx), 0);
    chk("rst_h", 32'(bus.h_idx), 0);
    chk("rst_w", 32'(bus.w_idx), 0);
    chk("rst_mv", 32'(bus.m_tvalid), 0);

    // streaming: one image of four windows
    obs_we = 0;
    img_at = -1;
    cyc_n = 0;
    for (int i = 0; i < 24; i++) cyc(0, 1, 1);
    chk("we_cnt24", obs_we, 4);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1);
    chk("img_tile", img_at, 24);

    // random handshakes over 100 windows
    cyc(1, 0, 0);
    n_done = 0;
    obs_x = 0;
    guard = 0;
    while (n_done < 100 && guard < 5000) begin
      cyc(0, ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1);
      guard++;
    end
    chk("win_done", n_done, 100);
    chk("xfer_cnt", obs_x, 100 * NT);

    // reset on tile 3 of window 2
    cyc(1, 0, 0);
    guard = 0;
    while (!(wn == 1 && tl == NT - 2) && guard < 50) begin
      cyc(0, 1, 1);
      guard++;
    end
    chk("mid_reach", 32'(wn == 1 && tl == NT - 2), 1);
    cyc(1, 1, 1);
    @(negedge clk);
    #1;
    chk("mr_mv", 32'(bus.m_tvalid), 0);
    chk("mr_h", 32'(bus.h_idx), 0);
    chk("mr_w", 32'(bus.w_idx), 0);
    for (int i = 0; i < 14; i++) cyc(0, 1, 1);

    // single-tile build: one window per cycle
    @(negedge clk);
    rst2 = 1'b0;
    b2.s_tvalid = 1'b1;
    b2.m_tready = 1'b1;
    #1;
    chk("d_rdy0", 32'(b2.s_tready), 1);
    chk("d_mv0", 32'(b2.m_tvalid), 0);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      #1;
      chk("d_mv", 32'(b2.m_tvalid), 1);
      chk("d_we", 32'(b2.buf_we), 1);
      chk("d_lw", 32'(b2.last_win), 1);
      chk("d_w", 32'(b2.w_idx), j % IW);
      chk("d_h", 32'(b2.h_idx), (j / IW) % IH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
